spi_prog_loader: RTL and testbench
==================================

Name: spi_prog_loader

Overview:
- SPI-slave program loader inside mpw_top, directly downstream of the external SPI master.
- Deserializes the SCLK/CS/MOSI byte stream, decodes address and data commands, and issues 32-bit word writes to the instruction memory, data memory and SRAM write port.
- This is how bios images and SRAM contents are flashed while the core is held in reset.

Parameters:
- ADDR_W, 32, width of the write address.
- DATA_W, 32, width of the write data. Must be a multiple of 8.
- SYNC_STAGES, 2, flip-flop stages on the sclk, cs_n and mosi inputs.
- OP_ADDR, 8'h01, opcode that starts an address load.
- OP_DATA, 8'h02, opcode that starts a data load and write.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- sclk_i  in  1  SPI clock, asynchronous to clk_i.
- cs_ni  in  1  SPI chip select, active low.
- mosi_i  in  1  SPI serial data in.
- miso_o  out  1  SPI serial data out; echoes the previously received byte.
- mem_req_o  out  1  write request.
- mem_addr_o  out  ADDR_W  write address.
- mem_wdata_o  out  DATA_W  write data.
- mem_ready_i  in  1  write accepted in this cycle when high together with mem_req_o.
- busy_o  out  1  high when the FSM is not in IDLE.
- err_o  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (asynchronous, rst_ni low) clears everything immediately:
  - miso_o=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, busy_o=0, err_o=0.
  - FSM goes to IDLE. Bit counter, byte counter, shift register and echo register are zeroed.
  - A pending write is dropped; a partial byte is discarded.
- Input synchronization: sclk_i, cs_ni and mosi_i each pass through SYNC_STAGES flops; reset values sclk=0, cs_n=1, mosi=0.
  - Edges are detected on the synchronized sclk.
  - clk_i must be at least 4x the sclk frequency.
- SPI framing:
  - Mode 0 (CPOL=0, CPHA=0), MSB first.
  - MOSI is sampled on the synchronized sclk rising edge while cs_n=0.
  - miso_o shifts the echo register MSB first, updating on the sclk falling edge.
- Byte completion:
  - On the 8th rising edge, byte_valid pulses for 1 clk.
  - The byte is copied to the echo register and the bit counter returns to 0.
- cs_n deassertion:
  - Resets the bit counter and discards any partial byte (fewer than 8 bits); no byte_valid is generated.
  - FSM state and byte counter are preserved. The master may toggle cs_n between every byte.
- FSM, all transitions taken on byte_valid unless noted:
  - IDLE:
    - byte==OP_ADDR goes to ADDR.
    - byte==OP_DATA goes to DATA.
    - Any other byte stays in IDLE and sets err_o.
  - ADDR: collects 4 bytes MSB first into the address shadow register. On the 4th byte, mem_addr_o is updated and the FSM returns to IDLE.
  - DATA: collects DATA_W/8 bytes MSB first into mem_wdata_o. On the last byte, the FSM goes to WRITE and mem_req_o=1 on the next clk.
  - WRITE:
    - mem_req_o, mem_addr_o and mem_wdata_o are held stable until mem_ready_i=1.
    - In that cycle the write is accepted; mem_req_o is 0 on the next clk and the FSM returns to IDLE.
    - mem_ready_i may already be high when mem_req_o rises; the write then completes in 1 cycle.
    - A byte_valid arriving while in WRITE is dropped and sets err_o.
    - If the write is accepted in the same cycle as a byte_valid, that byte is processed in IDLE (no error).
- Latency: mem_req_o rises 1 clk after byte_valid of the last data byte.
- The address is not modified by a write unless AUTO_INC_EN is defined. Addresses are passed through unaligned; the byte counter wraps to 0 on each state exit.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: SPI_PROG_LOADER_AUTO_INC_EN.
- When defined: on write acceptance, mem_addr_o += DATA_W/8, with modulo 2^ADDR_W wrap (0xFFFF_FFFC goes to 0x0000_0000). Consecutive OP_DATA frames then fill sequential words without resending OP_ADDR.
- When undefined: mem_addr_o changes only on completion of an OP_ADDR frame.

Test Plan:
- Address then data: send 01 10 00 00 00, then 02 DE AD BE EF with cs_n toggled per byte, mem_ready_i=1 → exactly one write, addr=0x1000_0000, wdata=0xDEADBEEF, mem_req_o high for 1 clk, err_o=0.
- Write backpressure: mem_ready_i=0 for 20 clk after mem_req_o rises → mem_req_o, addr and wdata stay stable for 20 clk, then the write completes and busy_o falls 1 clk after acceptance.
- Bad opcode and collision:
  - Send byte 0x55 in IDLE → err_o=1, state stays IDLE, no write.
  - Send a byte during WRITE while mem_ready_i=0 → err_o=1 and the byte is dropped.
- Partial byte: raise cs_n after 5 bits, then send 02 00 00 00 07 → write wdata=0x0000_0007 with no corruption from the partial byte.
- Reset mid-DATA: assert rst_ni low after 2 data bytes → all outputs 0 immediately; a subsequent 01 20 00 00 00 / 02 11 22 33 44 writes 0x11223344 to 0x2000_0000.
- Auto-increment (SPI_PROG_LOADER_AUTO_INC_EN defined): send 01 FF FF FF FC, then two 02 frames → writes go to 0xFFFF_FFFC, then 0x0000_0000. With the macro undefined, both writes go to 0xFFFF_FFFC.
- MISO echo: send 0xA5, then 0x3C → miso_o shifts out 0xA5 during the second byte.

Source files
------------

// File: rtl/spi_prog_loader.sv
// SPI-slave program loader: deserializes mode-0 bytes and issues word writes.
// Optional SPI_PROG_LOADER_AUTO_INC_EN: advance mem_addr_o after each accepted write.
`timescale 1ns/1ps

module spi_prog_loader #(
    parameter int         ADDR_W      = 32,
    parameter int         DATA_W      = 32,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] OP_ADDR     = 8'h01,
    parameter logic [7:0] OP_DATA     = 8'h02
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sclk_i,
    input  logic              cs_ni,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              err_o
);

    localparam int DATA_B = DATA_W / 8;
    localparam int ADDR_B = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        WRITE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;

    logic       sclk_s;
    logic       cs_s;
    logic       mosi_s;
    logic       sclk_d;
    logic       rise;
    logic       fall;

    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] echo;
    logic [7:0] tx;
    logic       byte_valid;
    logic [7:0] rx_next;

    state_t      state;
    logic [7:0]  byte_cnt;
    logic [31:0] addr_sh;
    logic [31:0] addr_next;
    state_t      op_state;
    logic        op_bad;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync[0] <= sclk_i;
            cs_sync[0]   <= cs_ni;
            mosi_sync[0] <= mosi_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync[i] <= sclk_sync[i-1];
                cs_sync[i]   <= cs_sync[i-1];
                mosi_sync[i] <= mosi_sync[i-1];
            end
        end
    end

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s  = mosi_sync[SYNC_STAGES-1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign rx_next = {shift[6:0], mosi_s};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_d     <= 1'b0;
            bit_cnt    <= '0;
            shift      <= '0;
            echo       <= '0;
            tx         <= '0;
            miso_o     <= 1'b0;
            byte_valid <= 1'b0;
        end else begin
            sclk_d     <= sclk_s;
            byte_valid <= 1'b0;
            if (cs_s) begin
                bit_cnt <= '0;
                shift   <= '0;
                // Re-arm the echo so a partial frame cannot misalign it.
                tx      <= {echo[6:0], 1'b0};
                miso_o  <= echo[7];
            end else begin
                if (rise) begin
                    shift   <= rx_next;
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_valid <= 1'b1;
                        echo       <= rx_next;
                        tx         <= rx_next;
                    end
                end
                if (fall) begin
                    miso_o <= tx[7];
                    tx     <= {tx[6:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        op_state = IDLE;
        op_bad   = 1'b0;
        if (echo == OP_ADDR) begin
            op_state = ADDR;
        end else if (echo == OP_DATA) begin
            op_state = DATA;
        end else begin
            op_bad = 1'b1;
        end
    end

    assign addr_next = (addr_sh << 8) | 32'(echo);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            addr_sh     <= '0;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (byte_valid) begin
                        state    <= op_state;
                        busy_o   <= (op_state != IDLE);
                        err_o    <= err_o | op_bad;
                        byte_cnt <= '0;
                    end
                end
                ADDR: begin
                    if (byte_valid) begin
                        addr_sh <= addr_next;
                        if (byte_cnt == 8'(ADDR_B - 1)) begin
                            mem_addr_o <= ADDR_W'(addr_next);
                            state      <= IDLE;
                            busy_o     <= 1'b0;
                            byte_cnt   <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                DATA: begin
                    if (byte_valid) begin
                        mem_wdata_o <= (mem_wdata_o << 8) | DATA_W'(echo);
                        if (byte_cnt == 8'(DATA_B - 1)) begin
                            state     <= WRITE;
                            mem_req_o <= 1'b1;
                            byte_cnt  <= '0;
                        end else begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
`ifdef SPI_PROG_LOADER_AUTO_INC_EN
                        mem_addr_o <= mem_addr_o + ADDR_W'(DATA_B);
`endif
                        // A byte landing on the accept cycle is decoded as IDLE.
                        if (byte_valid) begin
                            state  <= op_state;
                            busy_o <= (op_state != IDLE);
                            err_o  <= err_o | op_bad;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                        byte_cnt <= '0;
                    end else if (byte_valid) begin
                        err_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_prog_loader.sv
// Bench for spi_prog_loader: SPI master driver, byte-level reference model
// and per-cycle write scoreboard.
`timescale 1ns/1ps

module tb_spi_prog_loader;

    localparam int H = 60;
`ifdef SPI_PROG_LOADER_AUTO_INC_EN
    localparam bit INC = 1'b1;
`else
    localparam bit INC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic        mosi = 1'b0;
    logic        ready = 1'b1;
    logic        miso;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    spi_prog_loader dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .sclk_i      (sclk),
        .cs_ni       (cs_n),
        .mosi_i      (mosi),
        .miso_o      (miso),
        .mem_req_o   (req),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .mem_ready_i (ready),
        .busy_o      (busy),
        .err_o       (err)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    wr_t         exp_q[$];
    logic [7:0]  m_buf[$];
    int          m_cmd = 0;
    logic [31:0] m_addr = '0;
    logic        exp_err = 1'b0;
    logic        m_pending = 1'b0;
    logic [7:0]  m_last = '0;
    int          n_writes = 0;
    int          req_cycles = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_data = '0;
    bit          hold_ready = 1'b0;
    int          ready_delay = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Protocol-level interpretation of one complete received byte.
    task automatic model_byte(input logic [7:0] b);
        logic [31:0] word;
        if (m_pending) begin
            exp_err = 1'b1;
        end else if (m_cmd == 0) begin
            if (b == 8'h01) m_cmd = 1;
            else if (b == 8'h02) m_cmd = 2;
            else exp_err = 1'b1;
            m_buf.delete();
        end else begin
            m_buf.push_back(b);
            if (m_buf.size() == 4) begin
                word = {m_buf[0], m_buf[1], m_buf[2], m_buf[3]};
                if (m_cmd == 1) begin
                    m_addr = word;
                end else begin
                    exp_q.push_back({m_addr, word});
                    m_pending = 1'b1;
                    if (INC) m_addr = m_addr + 32'd4;
                end
                m_cmd = 0;
                m_buf.delete();
            end
        end
        m_last = b;
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_buf.delete();
        m_cmd = 0;
        m_addr = '0;
        exp_err = 1'b0;
        m_pending = 1'b0;
        m_last = '0;
    endtask

    // mem_ready_i driver: optional hold, then ready after ready_delay cycles.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) begin
                ready = 1'b0;
            end else if (!req) begin
                cnt = 0;
                ready = (ready_delay == 0);
            end else if (cnt >= ready_delay) begin
                ready = 1'b1;
            end else begin
                ready = 1'b0;
                cnt++;
            end
        end
    end

    wr_t         cur;
    logic        p_hold = 1'b0;
    logic        p_acc = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_hold = 1'b0;
                p_acc  = 1'b0;
            end else begin
                if (p_hold) begin
                    chk("hold_req", 32'(req), 32'd1);
                    chk("hold_addr", addr, p_addr);
                    chk("hold_data", wdata, p_data);
                end
                if (p_acc) begin
                    chk("req_drop", 32'(req), 32'd0);
                    chk("busy_drop", 32'(busy), 32'd0);
                end
                if (req) begin
                    req_cycles++;
                    chk("busy_req", 32'(busy), 32'd1);
                end
                if (req && ready) begin
                    chk("write_expected", 32'(m_pending), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        chk("wr_addr", addr, cur.a);
                        chk("wr_data", wdata, cur.d);
                    end
                    m_pending = 1'b0;
                    n_writes++;
                    last_addr = addr;
                    last_data = wdata;
                end
                p_hold = req && !ready;
                p_acc  = req && ready;
                p_addr = addr;
                p_data = wdata;
            end
        end
    end

    task automatic spi_bits(input logic [7:0] b, input int nbits,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            #H;
            sclk = 1'b1;
            rx[7-i] = miso;
            if (nbits == 8) begin
                chk("miso_bit", 32'(miso), 32'(m_last[7-i]));
                if (i == 7) model_byte(b);
            end
            #H;
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] rx;
        cs_n = 1'b0;
        #H;
        spi_bits(b, 8, rx);
        #H;
        cs_n = 1'b1;
        #(2*H);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] w,
                            input bit toggle);
        logic [7:0] bs[5];
        logic [7:0] rx;
        bs = '{op, w[31:24], w[23:16], w[15:8], w[7:0]};
        if (toggle) begin
            for (int i = 0; i < 5; i++) send_byte(bs[i]);
        end else begin
            cs_n = 1'b0;
            #H;
            for (int i = 0; i < 5; i++) spi_bits(bs[i], 8, rx);
            #H;
            cs_n = 1'b1;
            #(2*H);
        end
    endtask

    task automatic partial(input int nbits, input logic [7:0] b);
        logic [7:0] rx;
        cs_n = 1'b0;
        #H;
        spi_bits(b, nbits, rx);
        #H;
        cs_n = 1'b1;
        #(2*H);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy || req || exp_q.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < bound), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_addr", addr, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        int         n0;
        int         n_data;
        bit         is_data;

        #2;
        do_reset();

        // Address then data, cs_n toggled per byte.
        req_cycles = 0;
        n0 = n_writes;
        send_cmd(8'h01, 32'h1000_0000, 1'b1);
        send_cmd(8'h02, 32'hDEAD_BEEF, 1'b1);
        wait_idle(300);
        chk("t1_nwr", 32'(n_writes - n0), 32'd1);
        chk("t1_addr", last_addr, 32'h1000_0000);
        chk("t1_data", last_data, 32'hDEAD_BEEF);
        chk("t1_reqcyc", 32'(req_cycles), 32'd1);
        chk("t1_err", 32'(err), 32'd0);

        // Backpressure: ready low for 20 cycles after req rises.
        ready_delay = 20;
        req_cycles = 0;
        send_cmd(8'h02, 32'hCAFE_F00D, 1'b0);
        wait_idle(300);
        ready_delay = 0;
        chk("t2_reqcyc", 32'(req_cycles), 32'd21);
        chk("t2_addr", last_addr, INC ? 32'h1000_0004 : 32'h1000_0000);
        chk("t2_data", last_data, 32'hCAFE_F00D);

        // Partial byte is discarded.
        partial(5, 8'hFF);
        send_cmd(8'h02, 32'h0000_0007, 1'b1);
        wait_idle(300);
        chk("t3_data", last_data, 32'h0000_0007);
        chk("t3_err", 32'(err), 32'(exp_err));

        // Address wrap with two data frames.
        send_cmd(8'h01, 32'hFFFF_FFFC, 1'b1);
        send_cmd(8'h02, 32'h0000_0001, 1'b0);
        wait_idle(300);
        chk("t4_addr0", last_addr, 32'hFFFF_FFFC);
        send_cmd(8'h02, 32'h0000_0002, 1'b1);
        wait_idle(300);
        chk("t4_addr1", last_addr, INC ? 32'h0000_0000 : 32'hFFFF_FFFC);
        chk("t4_data1", last_data, 32'h0000_0002);

        // Reset in the middle of a data frame.
        send_cmd(8'h01, 32'h3000_0000, 1'b1);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'hBB);
        chk("t5_busy_pre", 32'(busy), 32'd1);
        do_reset();
        send_cmd(8'h01, 32'h2000_0000, 1'b1);
        send_cmd(8'h02, 32'h1122_3344, 1'b1);
        wait_idle(300);
        chk("t5_addr", last_addr, 32'h2000_0000);
        chk("t5_data", last_data, 32'h1122_3344);

        // Byte during WRITE is dropped and flags an error.
        hold_ready = 1'b1;
        n0 = n_writes;
        send_cmd(8'h02, 32'h5566_7788, 1'b1);
        repeat (5) @(negedge clk);
        chk("t6_req", 32'(req), 32'd1);
        chk("t6_err_pre", 32'(err), 32'd0);
        send_byte(8'h02);
        repeat (10) @(negedge clk);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_err_model", 32'(err), 32'(exp_err));
        chk("t6_data_held", wdata, 32'h5566_7788);
        hold_ready = 1'b0;
        wait_idle(300);
        chk("t6_nwr", 32'(n_writes - n0), 32'd1);
        chk("t6_addr", last_addr, INC ? 32'h2000_0004 : 32'h2000_0000);
        send_cmd(8'h01, 32'h1234_5678, 1'b1);
        send_cmd(8'h02, 32'hCAFE_BABE, 1'b0);
        wait_idle(300);
        chk("t6_after_addr", last_addr, 32'h1234_5678);
        chk("t6_after_data", last_data, 32'hCAFE_BABE);

        // Bad opcode in IDLE.
        do_reset();
        n0 = n_writes;
        send_byte(8'h55);
        repeat (10) @(negedge clk);
        chk("t7_err", 32'(err), 32'd1);
        chk("t7_busy", 32'(busy), 32'd0);
        chk("t7_nwr", 32'(n_writes - n0), 32'd0);

        // MISO echoes the previous byte.
        send_byte(8'hA5);
        cs_n = 1'b0;
        #H;
        spi_bits(8'h3C, 8, rx);
        #H;
        cs_n = 1'b1;
        #(2*H);
        chk("t8_echo", 32'(rx), 32'h0000_00A5);
        chk("t8_err", 32'(err), 32'(exp_err));

        // Randomized frames with random backpressure.
        do_reset();
        n0 = n_writes;
        n_data = 0;
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 7) == 0)
                partial($urandom_range(1, 7), 8'($urandom));
            is_data = ($urandom_range(0, 3) != 0);
            ready_delay = $urandom_range(0, 6);
            send_cmd(is_data ? 8'h02 : 8'h01, $urandom, 1'($urandom));
            if (is_data) n_data++;
            wait_idle(300);
        end
        ready_delay = 0;
        chk("rnd_nwr", 32'(n_writes - n0), 32'(n_data));
        chk("rnd_err", 32'(err), 32'(exp_err));
        chk("rnd_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
